// File: rtl/linear_result_reader.sv
// linear_result_reader: streams words out of the bar2 result memory.
// Sequential reads go to a fixed-latency read port. Returning words are
// buffered in a small FIFO and presented on a valid/ready stream. A credit
// rule (in-flight reads plus buffered words) keeps the FIFO from overflowing.
module linear_result_reader #(
  parameter int WIDTH      = 64,
  parameter int RD_LAT     = 7,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [15:0]      num_words,
  output logic             busy,
  output logic             done,
  output logic             write_en_bar2,
  output logic [WIDTH-1:0] data_in_bar2,
  output logic [31:0]      addr_bar2,
  input  logic [WIDTH-1:0] data_out_bar2,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;

  state_t            state;
  logic [15:0]       total;
  logic [15:0]       issued;
  logic [15:0]       popped;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     fifo_count;
  logic [RD_LAT-1:0] tag_sr;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [WIDTH-1:0]  fifo_mem [FIFO_DEPTH];

  logic              issue;
  logic              push;
  logic              pop;
  logic [CW:0]       credit_used;

  // This block only reads memory.
  assign write_en_bar2 = 1'b0;
  assign data_in_bar2  = '0;

  // A read issues only when every outstanding and buffered word still fits in the FIFO.
  always_comb begin
    credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    issue       = (state == RUN) && (issued < total) &&
                  (credit_used < (CW+1)'(FIFO_DEPTH));
    push        = tag_sr[RD_LAT-1];
    pop         = m_valid && m_ready;
  end

  // Stream side shows the FIFO head. Data reads as zero while the FIFO is empty.
  always_comb begin
    m_valid = (fifo_count != '0);
    m_data  = m_valid ? fifo_mem[rd_ptr] : '0;
    m_last  = m_valid && (popped == total - 16'd1);
  end

  // Control FSM, address generation and transfer counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      addr_bar2 <= '0;
      total     <= '0;
      issued    <= '0;
      popped    <= '0;
    end else begin
      if (pop) popped <= popped + 16'd1;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // A zero-length job passes through RUN for one cycle and issues nothing.
            // This gives it the same done timing as the normal FIN entry.
            state  <= RUN;
            busy   <= 1'b1;
            total  <= num_words;
            issued <= '0;
            popped <= '0;
            if (num_words != 16'd0) addr_bar2 <= base_addr;
          end
        end
        RUN: begin
          if (total == 16'd0) begin
            state <= FIN;
            done  <= 1'b1;
          end else if (issue) begin
            issued    <= issued + 16'd1;
            addr_bar2 <= addr_bar2 + 32'(ADDR_STEP);
            if (issued == total - 16'd1) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The return tag pipeline marks the cycle in which each issued read's data arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) tag_sr <= '0;
    else        tag_sr <= {tag_sr[RD_LAT-2:0], issue};
  end

  // Track reads in flight and the FIFO occupancy. These two counts feed the credit check.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      case ({issue, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // FIFO storage. The credit rule guarantees that a push never overwrites an unread word.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= data_out_bar2;
  end

endmodule

// File: tb/tb_linear_result_reader.sv
// Testbench for linear_result_reader. A delayed-address memory model returns
// data RD_LAT cycles after each address. Expected stream contents come from
// address-order arithmetic.
module tb_linear_result_reader;

  localparam int WIDTH      = 64;
  localparam int RD_LAT     = 7;
  localparam int FIFO_DEPTH = 16;
  localparam int ADDR_STEP  = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      base_addr = '0;
  logic [15:0]      num_words = '0;
  logic             busy, done, write_en_bar2;
  logic [WIDTH-1:0] data_in_bar2;
  logic [31:0]      addr_bar2;
  logic [WIDTH-1:0] data_out_bar2;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  linear_result_reader #(
    .WIDTH(WIDTH), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_STEP(ADDR_STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done),
    .write_en_bar2(write_en_bar2), .data_in_bar2(data_in_bar2),
    .addr_bar2(addr_bar2), .data_out_bar2(data_out_bar2),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  function automatic logic [63:0] word_at(input logic [31:0] a);
    return {32'h0, a} * 64'h0101_0101_0101_0101;
  endfunction

  // Memory model: the word for the address presented RD_LAT cycles earlier.
  logic [31:0] ahist [RD_LAT];
  always @(posedge clk) begin
    ahist[0] <= addr_bar2;
    for (int i = 1; i < RD_LAT; i++) ahist[i] <= ahist[i-1];
  end
  assign data_out_bar2 = word_at(ahist[RD_LAT-1]);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", m_valid); end
    n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL reset_last got %b want 0", m_last); end
    n_cmp++; if (m_data !== '0) begin n_bad++; $display("FAIL reset_data got %h want 0", m_data); end
    n_cmp++; if (addr_bar2 !== '0) begin n_bad++; $display("FAIL reset_addr got %h want 0", addr_bar2); end
    n_cmp++; if (write_en_bar2 !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b want 0", write_en_bar2); end
    n_cmp++; if (data_in_bar2 !== '0) begin n_bad++; $display("FAIL reset_din got %h want 0", data_in_bar2); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Cycle-exact check of the 8-word example transfer.
  task automatic test_basic();
    logic exp_v;
    @(negedge clk);
    start = 1'b1; base_addr = 32'h10; num_words = 16'd8; m_ready = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      start = 1'b0;
      exp_v = (k >= 9) && (k <= 16);
      if (k <= 8) begin
        n_cmp++;
        if (addr_bar2 !== 32'h10 + 32'(k - 1)) begin
          n_bad++; $display("FAIL basic_addr cyc %0d got %h want %h", k, addr_bar2, 32'h10 + 32'(k - 1));
        end
      end
      n_cmp++;
      if (m_valid !== exp_v) begin n_bad++; $display("FAIL basic_valid cyc %0d got %b want %b", k, m_valid, exp_v); end
      if (exp_v) begin
        n_cmp++;
        if (m_data !== word_at(32'h10 + 32'(k - 9))) begin
          n_bad++; $display("FAIL basic_data cyc %0d got %h want %h", k, m_data, word_at(32'h10 + 32'(k - 9)));
        end
      end
      n_cmp++;
      if (m_last !== (k == 16)) begin n_bad++; $display("FAIL basic_last cyc %0d got %b want %b", k, m_last, (k == 16)); end
      n_cmp++;
      if (done !== (k == 17)) begin n_bad++; $display("FAIL basic_done cyc %0d got %b want %b", k, done, (k == 17)); end
      n_cmp++;
      if (busy !== (k <= 17)) begin n_bad++; $display("FAIL basic_busy cyc %0d got %b want %b", k, busy, (k <= 17)); end
    end
    m_ready = 1'b0;
  endtask

  // Drives one transfer and checks it against the address-order model.
  // mode 0: always ready. mode 1: ready low through cycle 40. mode 2: random ready.
  // poke_k > 0 re-asserts start with a different job in that cycle.
  task automatic run_transfer(input logic [31:0] base, input int n, input int mode, input int poke_k);
    int k, popped, dones, done_k, last_k;
    logic pv, pr, pl;
    logic [WIDTH-1:0] pd;
    logic [31:0] iss;
    logic finished;
    k = 0; popped = 0; dones = 0; done_k = 0; last_k = -1; finished = 1'b0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    @(negedge clk);
    start = 1'b1; base_addr = base; num_words = n[15:0]; m_ready = 1'b0;
    while (!finished && k < 3000) begin
      @(negedge clk);
      k++;
      start = (k == poke_k);
      if (k == poke_k) begin base_addr = base ^ 32'h5555_0000; num_words = 16'd3; end
      iss = (addr_bar2 - base) / 32'(ADDR_STEP);
      n_cmp++;
      if (iss > 32'(popped + FIFO_DEPTH) || iss > 32'(n)) begin
        n_bad++; $display("FAIL credit cyc %0d issued %0d popped %0d limit %0d", k, iss, popped, FIFO_DEPTH);
      end
      if (pv && !pr) begin
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== pd || m_last !== pl) begin
          n_bad++; $display("FAIL hold cyc %0d got v%b %h l%b want v1 %h l%b", k, m_valid, m_data, m_last, pd, pl);
        end
      end
      if (done === 1'b1) begin
        dones++; done_k = k;
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL done_busy cyc %0d busy %b want 1", k, busy); end
      end
      if (dones > 0 && k > done_k) begin
        n_cmp++;
        if (m_valid !== 1'b0) begin n_bad++; $display("FAIL post_valid cyc %0d got %b want 0", k, m_valid); end
      end
      if (mode == 1 && k == 40) begin
        n_cmp++;
        if (addr_bar2 !== base + 32'(FIFO_DEPTH * ADDR_STEP)) begin
          n_bad++; $display("FAIL stall_addr got %h want %h", addr_bar2, base + 32'(FIFO_DEPTH * ADDR_STEP));
        end
      end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (k > 40);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (m_valid === 1'b1 && m_ready) begin
        n_cmp++;
        if (popped >= n) begin
          n_bad++; $display("FAIL extra_beat cyc %0d data %h beyond %0d words", k, m_data, n);
        end else if (m_data !== word_at(base + 32'(popped * ADDR_STEP)) || m_last !== (popped == n - 1)) begin
          n_bad++; $display("FAIL beat %0d got %h l%b want %h l%b", popped, m_data, m_last,
                            word_at(base + 32'(popped * ADDR_STEP)), (popped == n - 1));
        end
        popped++; last_k = k;
      end
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
      if (dones > 0 && k >= done_k + 3) finished = 1'b1;
    end
    m_ready = 1'b0; start = 1'b0;
    n_cmp++; if (!finished) begin n_bad++; $display("FAIL xfer_timeout got dones %0d want 1", dones); end
    n_cmp++; if (popped != n) begin n_bad++; $display("FAIL beat_count got %0d want %0d", popped, n); end
    n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL done_count got %0d want 1", dones); end
    n_cmp++; if (done_k != last_k + 1) begin n_bad++; $display("FAIL done_timing got %0d want %0d", done_k, last_k + 1); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    run_transfer($urandom & 32'h0fff_fff0, 64, 1, 0);
  endtask

  task automatic test_random_ready();
    run_transfer($urandom, 64, 2, 0);
  endtask

  task automatic test_restart_ignored();
    run_transfer($urandom & 32'h00ff_ffff, 20, 2, 5);
  endtask

  task automatic test_zero();
    logic [31:0] a0;
    @(negedge clk);
    a0 = addr_bar2;
    start = 1'b1; base_addr = a0 + 32'h100; num_words = 16'd0; m_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      n_cmp++; if (done !== (k == 2)) begin n_bad++; $display("FAIL zero_done cyc %0d got %b want %b", k, done, (k == 2)); end
      n_cmp++; if (busy !== (k <= 2)) begin n_bad++; $display("FAIL zero_busy cyc %0d got %b want %b", k, busy, (k <= 2)); end
      n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL zero_valid cyc %0d got %b want 0", k, m_valid); end
      n_cmp++; if (addr_bar2 !== a0) begin n_bad++; $display("FAIL zero_addr cyc %0d got %h want %h", k, addr_bar2, a0); end
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; base_addr = $urandom & 32'h0fff_ffff; num_words = 16'd32; m_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 12) rst_n = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done got %b want 0", done); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %b want 0", m_valid); end
    n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL rstmid_last got %b want 0", m_last); end
    n_cmp++; if (m_data !== '0) begin n_bad++; $display("FAIL rstmid_data got %h want 0", m_data); end
    n_cmp++; if (addr_bar2 !== '0) begin n_bad++; $display("FAIL rstmid_addr got %h want 0", addr_bar2); end
    for (int k = 14; k <= 30; k++) begin
      @(negedge clk);
      n_cmp++;
      if (m_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL rstmid_quiet cyc %0d got v%b d%b b%b want 000", k, m_valid, done, busy);
      end
    end
    m_ready = 1'b0;
    run_transfer($urandom, 10, 2, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random_ready();
    test_zero();
    test_restart_ignored();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
